// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - reference-tone sequencer: single held tone or A2..A3 sweep timed in audio samples
module tone_sequencer #(
    parameter int NOTE_SAMPLES = 48000,
    parameter int GAP_SAMPLES  = 4800,
    parameter int CNT_W        = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       loop_en,
    input  logic [2:0] note_sel,
    input  logic       sample_tick,
    output logic [6:0] note_num,
    output logic       tone_reset,
    output logic       busy,
    output logic [2:0] note_idx,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             mode_q;
    logic             loop_q;
    logic [2:0]       idx;
    state_t           adv_state;
    logic [2:0]       adv_idx;

    function automatic logic [6:0] note_rom(input logic [2:0] i);
        case (i)
            3'd0:    return 7'd22;
            3'd1:    return 7'd25;
            3'd2:    return 7'd29;
            3'd3:    return 7'd32;
            default: return 7'd34;
        endcase
    endfunction

    // Where the sweep goes once the current note (and its gap, if any) has finished.
    always_comb begin
        adv_state = LOAD;
        adv_idx   = idx + 3'd1;
        if (idx == 3'd4) begin
            adv_state = loop_q ? LOAD : DONE;
            adv_idx   = loop_q ? 3'd0 : idx;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            mode_q     <= 1'b0;
            loop_q     <= 1'b0;
            idx        <= 3'd0;
            note_num   <= 7'd0;
            tone_reset <= 1'b1;
            busy       <= 1'b0;
            note_idx   <= 3'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                state      <= IDLE;
                note_num   <= 7'd0;
                tone_reset <= 1'b1;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        note_num   <= 7'd0;
                        tone_reset <= 1'b1;
                        if (start && !stop) begin
                            mode_q <= mode;
                            loop_q <= loop_en;
                            idx    <= mode ? 3'd0 : ((note_sel > 3'd4) ? 3'd0 : note_sel);
                            busy   <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                    LOAD: begin
                        note_num   <= note_rom(idx);
                        note_idx   <= idx;
                        tone_reset <= 1'b0;
                        count      <= '0;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (sample_tick) begin
                            if (!mode_q) begin
                                // single tone never times out; counter parks at its terminal value
                                if (count != NOTE_LAST)
                                    count <= count + 1'b1;
                            end else if (count == NOTE_LAST) begin
                                count <= '0;
                                if (GAP_SAMPLES > 0) begin
                                    state      <= GAP;
                                    note_num   <= 7'd0;
                                    tone_reset <= 1'b1;
                                end else begin
                                    state <= adv_state;
                                    idx   <= adv_idx;
                                    if (adv_state == DONE) begin
                                        done       <= 1'b1;
                                        note_num   <= 7'd0;
                                        tone_reset <= 1'b1;
                                    end
                                end
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (sample_tick) begin
                            if (count == GAP_LAST) begin
                                count <= '0;
                                state <= adv_state;
                                idx   <= adv_idx;
                                if (adv_state == DONE) begin
                                    done       <= 1'b1;
                                    note_num   <= 7'd0;
                                    tone_reset <= 1'b1;
                                end
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer, gapped (a) and gapless (b) builds side by side
module tb_tone_sequencer;

    localparam int NA = 4;
    localparam int GA = 2;
    localparam int NB = 3;
    localparam int GB = 0;
    localparam int ROM[5] = '{22, 25, 29, 32, 34};
    localparam int K_LEAD = 0;
    localparam int K_TONE = 1;
    localparam int K_GAP  = 2;
    localparam int K_DONE = 3;

    typedef struct packed {
        logic [6:0] nn;
        logic       tr;
        logic       bz;
        logic [2:0] ni;
        logic       dn;
    } out_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic       loop_en = 1'b0;
    logic [2:0] note_sel = 3'd0;
    logic       sample_tick = 1'b0;

    logic [6:0] nn_a, nn_b;
    logic       tr_a, tr_b, bz_a, bz_b, dn_a, dn_b;
    logic [2:0] ni_a, ni_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    out_t exp_a[$];
    out_t exp_b[$];

    out_t m_out[2];
    bit   m_act[2];
    bit   m_mode[2];
    bit   m_loop[2];
    int   m_sel[2];
    int   m_pos[2];
    int   m_left[2];

    tone_sequencer #(.NOTE_SAMPLES(NA), .GAP_SAMPLES(GA), .CNT_W(4)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .loop_en(loop_en), .note_sel(note_sel), .sample_tick(sample_tick),
        .note_num(nn_a), .tone_reset(tr_a), .busy(bz_a), .note_idx(ni_a), .done(dn_a)
    );

    tone_sequencer #(.NOTE_SAMPLES(NB), .GAP_SAMPLES(GB), .CNT_W(4)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .loop_en(loop_en), .note_sel(note_sel), .sample_tick(sample_tick),
        .note_num(nn_b), .tone_reset(tr_b), .busy(bz_b), .note_idx(ni_b), .done(dn_b)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int nsamp(int u);
        return (u == 0) ? NA : NB;
    endfunction

    function automatic int gsamp(int u);
        return (u == 0) ? GA : GB;
    endfunction

    // The session is a timeline of segments: per note a lead-in cycle, the tone, then a gap if any.
    task automatic seg_of(input int u, output int kind, output int note);
        int per;
        per = (gsamp(u) > 0) ? 3 : 2;
        if (!m_mode[u]) begin
            kind = (m_pos[u] == 0) ? K_LEAD : K_TONE;
            note = m_sel[u];
        end else if (m_pos[u] >= 5 * per) begin
            kind = K_DONE;
            note = 4;
        end else begin
            kind = m_pos[u] % per;
            note = m_pos[u] / per;
        end
    endtask

    task automatic m_enter(input int u);
        int kind, note;
        seg_of(u, kind, note);
        if (kind == K_LEAD) begin
            m_left[u] = 1;
        end else if (kind == K_TONE) begin
            m_left[u]    = m_mode[u] ? nsamp(u) : -1;
            m_out[u].nn = 7'(ROM[note]);
            m_out[u].ni = 3'(note);
            m_out[u].tr = 1'b0;
        end else if (kind == K_GAP) begin
            m_left[u]    = gsamp(u);
            m_out[u].nn = 7'd0;
            m_out[u].tr = 1'b1;
        end else begin
            m_left[u]    = 1;
            m_out[u].nn = 7'd0;
            m_out[u].tr = 1'b1;
            m_out[u].dn = 1'b1;
        end
    endtask

    task automatic m_step(input int u);
        int  kind, note, per;
        bit  fin;
        per = (gsamp(u) > 0) ? 3 : 2;
        if (reset) begin
            m_act[u] = 0; m_mode[u] = 0; m_loop[u] = 0; m_sel[u] = 0; m_pos[u] = 0;
            m_out[u] = '0;
            m_out[u].tr = 1'b1;
        end else begin
            m_out[u].dn = 1'b0;
            if (!m_act[u]) begin
                if (start && !stop) begin
                    m_act[u]  = 1;
                    m_mode[u] = mode;
                    m_loop[u] = loop_en;
                    m_sel[u]  = (note_sel > 3'd4) ? 0 : int'(note_sel);
                    m_pos[u]  = 0;
                    m_out[u].bz = 1'b1;
                    m_enter(u);
                end
            end else if (stop) begin
                m_act[u] = 0;
                m_out[u].nn = 7'd0;
                m_out[u].tr = 1'b1;
                m_out[u].bz = 1'b0;
            end else begin
                seg_of(u, kind, note);
                fin = 0;
                if (kind == K_LEAD || kind == K_DONE) begin
                    fin = 1;
                end else if (sample_tick && m_left[u] > 0) begin
                    m_left[u] = m_left[u] - 1;
                    fin = (m_left[u] == 0);
                end
                if (fin) begin
                    if (kind == K_DONE) begin
                        m_act[u] = 0;
                        m_out[u].bz = 1'b0;
                    end else begin
                        m_pos[u] = m_pos[u] + 1;
                        if (m_mode[u] && m_loop[u] && m_pos[u] == 5 * per)
                            m_pos[u] = 0;
                        m_enter(u);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        m_step(0);
        m_step(1);
        exp_a.push_back(m_out[0]);
        exp_b.push_back(m_out[1]);
    endtask

    task automatic run(input int n, input int every);
        for (int i = 0; i < n; i++) begin
            sample_tick = (every == 0) ? 1'($urandom % 2) : ((i % every) == every - 1);
            step();
        end
        sample_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_out(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got nn=%0d tr=%0b busy=%0b idx=%0d done=%0b, want nn=%0d tr=%0b busy=%0b idx=%0d done=%0b",
                     name, cyc, got.nn, got.tr, got.bz, got.ni, got.dn,
                     want.nn, want.tr, want.bz, want.ni, want.dn);
        end
    endtask

    // Monitor: every registered output update is compared against the oldest queued expectation.
    initial begin
        out_t want;
        forever begin
            @(posedge CLOCK_50);
            #3;
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_a_empty cycle=%0d got entries=0 want >=1", cyc);
            end else begin
                want = exp_a.pop_front();
                check_out("dut_a", {nn_a, tr_a, bz_a, ni_a, dn_a}, want);
            end
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_b_empty cycle=%0d got entries=0 want >=1", cyc);
            end else begin
                want = exp_b.pop_front();
                check_out("dut_b", {nn_b, tr_b, bz_b, ni_b, dn_b}, want);
            end
        end
    end

    initial begin
        int kind, note, guard;
        run(3, 1);
        #3 reset = 1'b0;
        run(2, 1);

        mode = 1'b0; note_sel = 3'd2;
        pulse_start();
        run(80, 1);
        pulse_stop();
        run(3, 1);

        mode = 1'b1; loop_en = 1'b0;
        pulse_start();
        run(130, 3);

        loop_en = 1'b1;
        pulse_start();
        loop_en = 1'b0;
        run(140, 3);
        guard = 0;
        seg_of(0, kind, note);
        while (kind != K_GAP && guard < 60) begin
            run(1, 1);
            seg_of(0, kind, note);
            guard++;
        end
        checks++;
        if (kind != K_GAP) begin
            errors++;
            $display("FAIL reach_gap got kind=%0d want kind=%0d", kind, K_GAP);
        end
        pulse_stop();
        run(3, 1);

        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        run(3, 1);

        mode = 1'b0; note_sel = 3'd1;
        pulse_start();
        run(5, 1);
        note_sel = 3'd3; mode = 1'b1;
        pulse_start();
        run(10, 1);
        pulse_stop();

        mode = 1'b0; note_sel = 3'd7;
        pulse_start();
        run(6, 2);
        pulse_stop();

        mode = 1'b1;
        pulse_start();
        run(25, 2);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({nn_a, tr_a, bz_a} !== {7'd0, 1'b1, 1'b0} || {nn_b, tr_b, bz_b} !== {7'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got a=%0d/%0b/%0b b=%0d/%0b/%0b want 0/1/0",
                     nn_a, tr_a, bz_a, nn_b, tr_b, bz_b);
        end
        run(2, 1);
        #3 reset = 1'b0;
        pulse_start();
        run(20, 1);
        pulse_stop();

        for (int i = 0; i < 1500; i++) begin
            start       = ($urandom % 10) == 0;
            stop        = ($urandom % 45) == 0;
            mode        = 1'($urandom);
            loop_en     = 1'($urandom);
            note_sel    = 3'($urandom);
            sample_tick = 1'($urandom);
            step();
        end
        start = 1'b0; stop = 1'b0; sample_tick = 1'b0;
        run(2, 1);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
